// File: rtl/ftdi_rx_frame_parser.sv
// FTDI RX frame parser: hunts for SYNC, reads LEN, forwards LEN payload
// words as an AXI-stream packet and checks the trailing checksum word.
//
// Ports:
//   clk, rst      : user clock, async active-high reset
//   s_t*          : 16-bit RX stream from the FTDI 245-fifo controller
//   m_t*          : payload stream, m_tlast on the final payload word
//   frame_done/ok : 1-cycle end-of-frame pulse, ok = checksum matched
//   frame_cnt     : good frames (wrapping)
//   err_cnt       : bad frames (saturating)

module ftdi_rx_frame_parser #(
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter int unsigned MAX_LEN   = 1024,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [15:0] s_tdata,
  input  logic [1:0]  s_tkeep,
  input  logic        s_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [15:0] m_tdata,
  output logic        m_tlast,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAY,
    ST_CSUM
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   rem_q;
  logic [15:0]   rem_d;
  logic [15:0]   csum_q;
  logic [15:0]   csum_d;
  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_d;
  logic          done_q;
  logic          done_d;
  logic          ok_q;
  logic          ok_d;
  logic [15:0]   fcnt_q;
  logic [15:0]   fcnt_d;
  logic [15:0]   ecnt_q;
  logic [15:0]   ecnt_d;

  logic          keep_ok;
  logic          beat;
  logic          len_bad;
  logic [IW-1:0] idle_inc;
  logic          idle_hit;
  logic          tmo;

  // Frame boundaries come from LEN, not from USB packet boundaries.
  logic unused_tlast;
  assign unused_tlast = s_tlast;

  assign keep_ok  = (s_tkeep == 2'b11);
  assign beat     = s_tvalid & s_tready;
  assign len_bad  = (s_tdata == 16'd0) ||
                    ({1'b0, s_tdata} > 17'(MAX_LEN));
  assign idle_inc = idle_q + IW'(1);
  assign idle_hit = (idle_inc == IW'(TIMEOUT));

  // Payload is a zero-latency pass-through, so the
  // stream side is combinational on the current state.
  assign m_tdata = s_tdata;

  always_comb begin
    s_tready = 1'b1;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    if (state_q == ST_PAY) begin
      s_tready = m_tready;
      m_tvalid = s_tvalid & keep_ok;
      m_tlast  = (rem_q == 16'd1);
    end
  end

  // Idle counter only runs while a frame is open and the
  // source is silent; back-pressure stalls never count.
  always_comb begin
    idle_d = idle_q;
    tmo    = 1'b0;
    if (state_q == ST_HUNT || beat) begin
      idle_d = '0;
    end else if (!s_tvalid) begin
      if (idle_hit) begin
        tmo    = 1'b1;
        idle_d = '0;
      end else begin
        idle_d = idle_inc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (beat && keep_ok && s_tdata == SYNC_WORD) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (beat) begin
          rem_d  = s_tdata;
          csum_d = s_tdata;
          if (!keep_ok || len_bad) begin
            done_d  = 1'b1;
            state_d = ST_HUNT;
          end else begin
            state_d = ST_PAY;
          end
        end
      end

      ST_PAY: begin
        if (beat) begin
          if (!keep_ok) begin
            done_d  = 1'b1;
            state_d = ST_HUNT;
          end else begin
            csum_d = csum_q + s_tdata;
            rem_d  = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = ST_CSUM;
            end
          end
        end
      end

      ST_CSUM: begin
        if (beat) begin
          done_d  = 1'b1;
          ok_d    = keep_ok && (s_tdata == csum_q);
          state_d = ST_HUNT;
        end
      end
    endcase

    // tmo implies s_tvalid=0, so it never races a beat.
    if (tmo) begin
      done_d  = 1'b1;
      ok_d    = 1'b0;
      state_d = ST_HUNT;
    end
  end

  // Counters follow the done/ok decision of the same
  // cycle, giving exactly one increment per frame.
  always_comb begin
    fcnt_d = fcnt_q;
    ecnt_d = ecnt_q;
    if (done_d && ok_d) begin
      fcnt_d = fcnt_q + 16'd1;
    end
    if (done_d && !ok_d && ecnt_q != 16'hFFFF) begin
      ecnt_d = ecnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      rem_q   <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign frame_cnt  = fcnt_q;
  assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_ftdi_rx_frame_parser.sv
// Testbench for ftdi_rx_frame_parser: frames are built in the bench and
// their expected payload and frame results are queued as they are built.

module tb_ftdi_rx_frame_parser;

  localparam logic [15:0] SYNC = 16'hA55A;
  localparam int MAXL = 1024;
  localparam int TMO  = 64;

  localparam int K_GOOD    = 0;
  localparam int K_BADSUM  = 1;
  localparam int K_BADLEN  = 2;
  localparam int K_KEEPLEN = 3;
  localparam int K_KEEPPAY = 4;
  localparam int K_KEEPSUM = 5;
  localparam int K_TMO     = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] s_tdata = '0;
  logic [1:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  ftdi_rx_frame_parser #(
    .SYNC_WORD(SYNC),
    .MAX_LEN  (MAXL),
    .TIMEOUT  (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [16:0] exp_pay[$];
  bit          exp_res[$];
  logic [15:0] fr_pay[$];
  int          mdl_good = 0;
  int          mdl_err  = 0;
  int          rdy_mode = 0;
  int          gap_mode = 0;
  int          cyc      = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = ((cyc % 150) < 100) ? 1'b0 : cyc[0];
    endcase
  end

  logic [16:0] mon_e;
  bit          mon_ok;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        if (exp_pay.size() == 0) begin
          chk("unexp_beat", {15'd0, m_tlast, m_tdata}, 32'hDEAD0000);
        end else begin
          mon_e = exp_pay.pop_front();
          chk("m_tdata", m_tdata, mon_e[15:0]);
          chk("m_tlast", m_tlast, mon_e[16]);
        end
      end
      if (frame_done) begin
        if (exp_res.size() == 0) begin
          chk("unexp_done", frame_done, 1'b0);
        end else begin
          mon_ok = exp_res.pop_front();
          if (mon_ok) mdl_good++;
          else if (mdl_err < 65535) mdl_err++;
          chk("frame_ok", frame_ok, mon_ok);
          chk("frame_cnt", frame_cnt, mdl_good[15:0]);
          chk("err_cnt", err_cnt, mdl_err[15:0]);
        end
      end
    end
  end

  function automatic int rgap();
    int r;
    if (gap_mode == 0) return 0;
    if (gap_mode == 2) return TMO - 1;
    r = $urandom_range(0, 31);
    if (r == 0) return TMO - 1;
    return r % 3;
  endfunction

  function automatic logic [1:0] badkeep();
    return 2'($urandom_range(0, 2));
  endfunction

  // Invariant: called and returns at posedge+1.
  task automatic send_beat(input logic [15:0] d, input logic [1:0] k,
                           input int gap);
    bit acc;
    int w;
    s_tvalid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    acc = 1'b0;
    w   = 0;
    while (!acc && w < 2000) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      w++;
    end
    chk("beat_accept", acc, 1'b1);
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_rand(input int n);
    fr_pay.delete();
    for (int i = 0; i < n; i++) fr_pay.push_back(16'($urandom));
  endtask

  // Payload comes from fr_pay; len only matters for the bad-LEN kinds.
  task automatic frame(input int kind, input logic [15:0] len,
                       input int cut);
    logic [15:0] sum;
    int n;
    send_beat(SYNC, 2'b11, rgap());
    if (kind == K_BADLEN) begin
      exp_res.push_back(1'b0);
      send_beat(len, 2'b11, rgap());
      return;
    end
    if (kind == K_KEEPLEN) begin
      exp_res.push_back(1'b0);
      send_beat(len, badkeep(), rgap());
      return;
    end
    n   = fr_pay.size();
    sum = 16'(n);
    send_beat(16'(n), 2'b11, rgap());
    for (int i = 0; i < n; i++) begin
      if (kind == K_KEEPPAY && i == cut) begin
        exp_res.push_back(1'b0);
        send_beat(fr_pay[i], badkeep(), rgap());
        return;
      end
      if (kind == K_TMO && i == cut) begin
        exp_res.push_back(1'b0);
        idle(TMO);
        return;
      end
      exp_pay.push_back({i == n - 1, fr_pay[i]});
      sum = sum + fr_pay[i];
      send_beat(fr_pay[i], 2'b11, rgap());
    end
    if (kind == K_TMO) begin
      exp_res.push_back(1'b0);
      idle(TMO);
      return;
    end
    exp_res.push_back(kind == K_GOOD);
    case (kind)
      K_BADSUM:  send_beat(sum + 16'($urandom_range(1, 65535)),
                           2'b11, rgap());
      K_KEEPSUM: send_beat(sum, badkeep(), rgap());
      default:   send_beat(sum, 2'b11, rgap());
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    logic [15:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_fcnt", frame_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_tready", s_tready, 1'b1);
    chk("rel_mvalid", m_tvalid, 1'b0);
    chk("rel_mlast", m_tlast, 1'b0);
    chk("rel_done", frame_done, 1'b0);
    chk("rel_ok", frame_ok, 1'b0);
    chk("rel_fcnt", frame_cnt, 16'd0);
    chk("rel_ecnt", err_cnt, 16'd0);
    @(posedge clk);
    #1;

    fr_pay = '{16'h0001, 16'h0002, 16'h0003};
    frame(K_GOOD, 16'd0, 0);
    idle(3);
    chk("t1_fcnt", frame_cnt, 16'd1);

    frame(K_BADSUM, 16'd0, 0);
    idle(3);
    chk("t2_ecnt", err_cnt, 16'd1);

    send_beat(16'h1234, 2'b11, 0);
    send_beat(16'hA55B, 2'b11, 0);
    frame(K_GOOD, 16'd0, 0);
    idle(3);
    chk("t3_fcnt", frame_cnt, 16'd2);
    chk("t3_ecnt", err_cnt, 16'd1);

    frame(K_BADLEN, 16'h0000, 0);
    frame(K_BADLEN, 16'h0401, 0);
    idle(3);
    chk("t4_ecnt", err_cnt, 16'd3);

    fill_rand(MAXL);
    frame(K_GOOD, 16'd0, 0);
    idle(3);
    chk("maxlen_fcnt", frame_cnt, 16'd3);

    fr_pay = '{16'h0001, 16'h0002, 16'h0003};
    rdy_mode = 2;
    frame(K_GOOD, 16'd0, 0);
    rdy_mode = 1;
    frame(K_GOOD, 16'd0, 0);
    rdy_mode = 0;
    idle(3);
    chk("t5_fcnt", frame_cnt, 16'd5);
    chk("t5_ecnt", err_cnt, 16'd3);

    fr_pay = '{16'h0001, 16'h0002};
    frame(K_TMO, 16'd0, 1);
    fr_pay = '{16'h0001, 16'h0002, 16'h0003};
    frame(K_GOOD, 16'd0, 0);
    idle(3);
    chk("t6_ecnt", err_cnt, 16'd4);
    chk("t6_fcnt", frame_cnt, 16'd6);

    gap_mode = 2;
    fill_rand(3);
    frame(K_GOOD, 16'd0, 0);
    idle(3);
    chk("gap_fcnt", frame_cnt, 16'd7);

    gap_mode = 1;
    for (int f = 0; f < 150; f++) begin
      rdy_mode = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          send_beat(SYNC, badkeep(), rgap());
        end else begin
          d = 16'($urandom);
          if (d == SYNC) d = d ^ 16'h0001;
          send_beat(d, 2'b11, rgap());
        end
      end
      n = $urandom_range(1, 6);
      fill_rand(n);
      r = $urandom_range(0, 13);
      case (r)
        6:  frame(K_BADSUM, 16'd0, 0);
        7:  frame(K_BADLEN, ($urandom_range(0, 1) == 0) ? 16'd0 :
                  16'($urandom_range(MAXL + 1, 65535)), 0);
        8:  frame(K_KEEPLEN, 16'($urandom_range(1, MAXL)), 0);
        9:  frame(K_KEEPPAY, 16'd0, $urandom_range(0, n - 1));
        10: frame(K_KEEPSUM, 16'd0, 0);
        11: frame(K_TMO, 16'd0, $urandom_range(0, n));
        default: frame(K_GOOD, 16'd0, 0);
      endcase
    end
    rdy_mode = 0;
    gap_mode = 0;
    idle(10);
    chk("end_pay_left", exp_pay.size(), 0);
    chk("end_res_left", exp_res.size(), 0);
    chk("end_fcnt", frame_cnt, mdl_good[15:0]);
    chk("end_ecnt", err_cnt, mdl_err[15:0]);

    send_beat(SYNC, 2'b11, 0);
    send_beat(16'd3, 2'b11, 0);
    exp_pay.push_back({1'b0, 16'h0005});
    send_beat(16'h0005, 2'b11, 0);
    rst = 1'b1;
    idle(2);
    chk("mrst_fcnt", frame_cnt, 16'd0);
    chk("mrst_ecnt", err_cnt, 16'd0);
    mdl_good = 0;
    mdl_err  = 0;
    rst = 1'b0;
    idle(5);
    chk("mrst_done", frame_done, 1'b0);
    fr_pay = '{16'h0001, 16'h0002, 16'h0003};
    frame(K_GOOD, 16'd0, 0);
    idle(3);
    chk("mrst_fcnt2", frame_cnt, 16'd1);
    chk("mrst_ecnt2", err_cnt, 16'd0);
    chk("mrst_res_left", exp_res.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
